// File: rtl/switch_input_port.sv
// Multi-channel switch input port: sync, debounce, edge events and overruns, read-to-clear CPU port.
// Optional irq register is enabled by defining SWITCH_IRQ_EN.
module switch_input_port #(
  parameter int NUM_SWITCHES    = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int REGISTER_WIDTH  = 16
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [NUM_SWITCHES-1:0]   switch,
  input  logic                      readEnable,
  input  logic [1:0]                readSelect,
  output logic [REGISTER_WIDTH-1:0] readData,
  output logic [NUM_SWITCHES-1:0]   switchLevel,
  output logic                      eventPending,
  output logic                      irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] SEL_LEVEL   = 2'd0;
  localparam logic [1:0] SEL_EVENT   = 2'd1;
  localparam logic [1:0] SEL_OVERRUN = 2'd2;
  localparam logic [1:0] SEL_COUNT   = 2'd3;

  logic [NUM_SWITCHES-1:0]   sync1;
  logic [NUM_SWITCHES-1:0]   sync2;
  logic [NUM_SWITCHES-1:0]   stable;
  logic [CNT_W-1:0]          db_cnt [NUM_SWITCHES];
  logic [NUM_SWITCHES-1:0]   accept;
  logic [NUM_SWITCHES-1:0]   rise;
  logic [NUM_SWITCHES-1:0]   fall;
  logic [NUM_SWITCHES-1:0]   edge_det;
  logic [NUM_SWITCHES-1:0]   event_bits;
  logic [NUM_SWITCHES-1:0]   overrun_bits;
  logic                      clr_event;
  logic                      clr_overrun;
  logic [REGISTER_WIDTH-1:0] read_mux;

  always_ff @(posedge clock) begin
    if (isReset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  // A channel accepts its new level on the cycle its counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_SWITCHES; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
    end
    rise = accept & sync2 & ~stable;
    fall = accept & ~sync2 & stable;
    case (EDGE_MODE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      stable <= '0;
      for (int i = 0; i < NUM_SWITCHES; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable <= (stable & ~accept) | (sync2 & accept);
      for (int i = 0; i < NUM_SWITCHES; i++) begin
        if ((sync2[i] == stable[i]) || accept[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign clr_event   = readEnable && (readSelect == SEL_EVENT);
  assign clr_overrun = readEnable && (readSelect == SEL_OVERRUN);

  // New edges are OR-ed in after the clear so a coincident edge is never lost.
  always_ff @(posedge clock) begin
    if (isReset) begin
      event_bits   <= '0;
      overrun_bits <= '0;
    end else begin
      event_bits   <= (event_bits & ~{NUM_SWITCHES{clr_event}}) | edge_det;
      overrun_bits <= (overrun_bits & ~{NUM_SWITCHES{clr_overrun}}) | (edge_det & event_bits);
    end
  end

  always_comb begin
    read_mux = '0;
    case (readSelect)
      SEL_LEVEL:   read_mux[NUM_SWITCHES-1:0] = stable;
      SEL_EVENT:   read_mux[NUM_SWITCHES-1:0] = event_bits;
      SEL_OVERRUN: read_mux[NUM_SWITCHES-1:0] = overrun_bits;
      SEL_COUNT:   read_mux = REGISTER_WIDTH'(NUM_SWITCHES);
      default:     read_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      readData <= '0;
    end else if (readEnable) begin
      readData <= read_mux;
    end
  end

  assign switchLevel  = stable;
  assign eventPending = |event_bits;

`ifdef SWITCH_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock) begin
    if (isReset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |event_bits;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with default parameters (4 channels, 16-cycle debounce, rising edges).
module tb_switch_input_port;

`ifdef SWITCH_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock;
  logic        isReset;
  logic [3:0]  switch;
  logic        readEnable;
  logic [1:0]  readSelect;
  logic [15:0] readData;
  logic [3:0]  switchLevel;
  logic        eventPending;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  switch_input_port #(
    .NUM_SWITCHES(4),
    .DEBOUNCE_CYCLES(16),
    .EDGE_MODE(0),
    .REGISTER_WIDTH(16)
  ) dut (
    .clock(clock),
    .isReset(isReset),
    .switch(switch),
    .readEnable(readEnable),
    .readSelect(readSelect),
    .readData(readData),
    .switchLevel(switchLevel),
    .eventPending(eventPending),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges; outputs are sampled 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_read(input logic [1:0] sel);
    readEnable = 1'b1;
    readSelect = sel;
    tick(1);
    readEnable = 1'b0;
  endtask

  task automatic test_reset;
    isReset    = 1'b1;
    switch     = 4'b0000;
    readEnable = 1'b0;
    readSelect = 2'd0;
    tick(2);
    isReset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      n_cmp++;
      if (readData !== 16'h0000) begin
        $display("FAIL reset_readData cycle %0d: got %h expected 0000", c, readData);
        n_fail++;
      end
      n_cmp++;
      if (switchLevel !== 4'b0000) begin
        $display("FAIL reset_level cycle %0d: got %b expected 0000", c, switchLevel);
        n_fail++;
      end
      n_cmp++;
      if (eventPending !== 1'b0) begin
        $display("FAIL reset_eventPending cycle %0d: got %b expected 0", c, eventPending);
        n_fail++;
      end
      n_cmp++;
      if (irq !== 1'b0) begin
        $display("FAIL reset_irq cycle %0d: got %b expected 0", c, irq);
        n_fail++;
      end
    end
  endtask

  task automatic test_clean_rise;
    switch = 4'b0001;
    tick(17);
    n_cmp++;
    if (switchLevel !== 4'b0000) begin
      $display("FAIL rise_early_level: got %b expected 0000", switchLevel);
      n_fail++;
    end
    tick(1);
    n_cmp++;
    if (switchLevel !== 4'b0001) begin
      $display("FAIL rise_level: got %b expected 0001", switchLevel);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b1) begin
      $display("FAIL rise_eventPending: got %b expected 1", eventPending);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h0001) begin
      $display("FAIL rise_event_read: got %h expected 0001", readData);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b0) begin
      $display("FAIL rise_event_cleared: got %b expected 0", eventPending);
      n_fail++;
    end
  endtask

  task automatic test_glitch;
    switch[1] = 1'b1;
    tick(10);
    switch[1] = 1'b0;
    tick(30);
    n_cmp++;
    if (switchLevel !== 4'b0001) begin
      $display("FAIL glitch_level: got %b expected 0001", switchLevel);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b0) begin
      $display("FAIL glitch_eventPending: got %b expected 0", eventPending);
      n_fail++;
    end
    switch[1] = 1'b1;
    tick(20);
    n_cmp++;
    if (switchLevel !== 4'b0011) begin
      $display("FAIL pulse_high_level: got %b expected 0011", switchLevel);
      n_fail++;
    end
    switch[1] = 1'b0;
    tick(20);
    n_cmp++;
    if (switchLevel !== 4'b0001) begin
      $display("FAIL pulse_low_level: got %b expected 0001", switchLevel);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b1) begin
      $display("FAIL pulse_eventPending: got %b expected 1", eventPending);
      n_fail++;
    end
    do_read(2'd0);
    n_cmp++;
    if (readData !== 16'h0001) begin
      $display("FAIL pulse_level_read: got %h expected 0001", readData);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h0002) begin
      $display("FAIL pulse_event_read: got %h expected 0002", readData);
      n_fail++;
    end
  endtask

  task automatic test_overrun;
    switch[2] = 1'b1;
    tick(20);
    switch[2] = 1'b0;
    tick(20);
    do_read(2'd2);
    n_cmp++;
    if (readData !== 16'h0000) begin
      $display("FAIL overrun_first_read: got %h expected 0000", readData);
      n_fail++;
    end
    switch[2] = 1'b1;
    tick(20);
    switch[2] = 1'b0;
    tick(20);
    do_read(2'd2);
    n_cmp++;
    if (readData !== 16'h0004) begin
      $display("FAIL overrun_read: got %h expected 0004", readData);
      n_fail++;
    end
    do_read(2'd2);
    n_cmp++;
    if (readData !== 16'h0000) begin
      $display("FAIL overrun_reread: got %h expected 0000", readData);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b1) begin
      $display("FAIL overrun_event_kept: got %b expected 1", eventPending);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h0004) begin
      $display("FAIL overrun_event_read: got %h expected 0004", readData);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b0) begin
      $display("FAIL overrun_event_cleared: got %b expected 0", eventPending);
      n_fail++;
    end
  endtask

  task automatic test_coincident;
    switch[3] = 1'b1;
    tick(17);
    readEnable = 1'b1;
    readSelect = 2'd1;
    tick(1);
    readEnable = 1'b0;
    n_cmp++;
    if (readData !== 16'h0000) begin
      $display("FAIL coincident_read: got %h expected 0000", readData);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b1) begin
      $display("FAIL coincident_event_kept: got %b expected 1", eventPending);
      n_fail++;
    end
    n_cmp++;
    if (switchLevel !== 4'b1001) begin
      $display("FAIL coincident_level: got %b expected 1001", switchLevel);
      n_fail++;
    end
    do_read(2'd3);
    n_cmp++;
    if (readData !== 16'h0004) begin
      $display("FAIL count_read: got %h expected 0004", readData);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h0008) begin
      $display("FAIL coincident_event_read: got %h expected 0008", readData);
      n_fail++;
    end
    n_cmp++;
    if (eventPending !== 1'b0) begin
      $display("FAIL coincident_event_cleared: got %b expected 0", eventPending);
      n_fail++;
    end
  endtask

  task automatic test_irq;
    tick(1);
    switch[1] = 1'b1;
    tick(17);
    n_cmp++;
    if ({eventPending, irq} !== 2'b00) begin
      $display("FAIL irq_idle: got ep=%b irq=%b expected ep=0 irq=0", eventPending, irq);
      n_fail++;
    end
    tick(1);
    n_cmp++;
    if ({eventPending, irq} !== 2'b10) begin
      $display("FAIL irq_lag: got ep=%b irq=%b expected ep=1 irq=0", eventPending, irq);
      n_fail++;
    end
    tick(1);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      $display("FAIL irq_rise: got %b expected %b", irq, IRQ_ON);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h0002) begin
      $display("FAIL irq_event_read: got %h expected 0002", readData);
      n_fail++;
    end
    n_cmp++;
    if ({eventPending, irq} !== {1'b0, IRQ_ON}) begin
      $display("FAIL irq_hold: got ep=%b irq=%b expected ep=0 irq=%b", eventPending, irq, IRQ_ON);
      n_fail++;
    end
    tick(1);
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_fall: got %b expected 0", irq);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_debounce;
    do_read(2'd0);
    n_cmp++;
    if (readData !== 16'h000B) begin
      $display("FAIL level_read_1011: got %h expected 000b", readData);
      n_fail++;
    end
    switch[2] = 1'b1;
    tick(18);
    n_cmp++;
    if ({switchLevel, eventPending} !== 5'b1111_1) begin
      $display("FAIL pre_reset_state: got level=%b ep=%b expected level=1111 ep=1", switchLevel, eventPending);
      n_fail++;
    end
    tick(1);
    switch[2] = 1'b0;
    tick(8);
    isReset = 1'b1;
    tick(1);
    isReset = 1'b0;
    n_cmp++;
    if (readData !== 16'h0000) begin
      $display("FAIL midreset_readData: got %h expected 0000", readData);
      n_fail++;
    end
    n_cmp++;
    if (switchLevel !== 4'b0000) begin
      $display("FAIL midreset_level: got %b expected 0000", switchLevel);
      n_fail++;
    end
    n_cmp++;
    if ({eventPending, irq} !== 2'b00) begin
      $display("FAIL midreset_flags: got ep=%b irq=%b expected ep=0 irq=0", eventPending, irq);
      n_fail++;
    end
    tick(17);
    n_cmp++;
    if (switchLevel !== 4'b0000) begin
      $display("FAIL held_early_level: got %b expected 0000", switchLevel);
      n_fail++;
    end
    tick(1);
    n_cmp++;
    if ({switchLevel, eventPending} !== 5'b1011_1) begin
      $display("FAIL held_release: got level=%b ep=%b expected level=1011 ep=1", switchLevel, eventPending);
      n_fail++;
    end
    do_read(2'd1);
    n_cmp++;
    if (readData !== 16'h000B) begin
      $display("FAIL held_event_read: got %h expected 000b", readData);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_overrun();
    test_coincident();
    test_irq();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
